// File: rtl/multicycle_datapath_pkg.sv
// Shared encodings for the multi-cycle datapath: FSM states, writeback/jump
// selectors, immediate formats, ALU opcodes and the immediate generator.
package multicycle_datapath_pkg;

    localparam int          DEFAULT_XLEN     = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [1:0] JUMP_BRANCH = 2'b00;
    localparam logic [1:0] JUMP_JAL    = 2'b01;
    localparam logic [1:0] JUMP_JALR   = 2'b10;
    localparam logic [1:0] JUMP_SEQ    = 2'b11;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // 32-bit sign-extended immediate; the caller widens it to XLEN.
    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input logic [2:0] sel);
        case (sel)
            IMM_I:   imm_gen = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm_gen = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm_gen = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_J:   imm_gen = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_U:   imm_gen = {inst[31:12], 12'h000};
            default: imm_gen = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_datapath_fsm.sv
// Instruction sequencer: owns the state register and the registered memory
// request / retire outputs of the multi-cycle datapath.
module mc_fsm
    import multicycle_datapath_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   imem_ready,
    input  logic   dmem_ready,
    input  logic   mem_rw,
    input  logic   mem_read,
    output state_t state,
    output logic   imem_req,
    output logic   dmem_req,
    output logic   dmem_we,
    output logic   retire
);

    // State transitions with requests raised on entry and dropped after the handshake edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_FETCH;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            retire   <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_req && imem_ready) begin
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    if (mem_rw || mem_read) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= mem_rw;
                        state    <= S_MEM;
                    end else begin
                        retire <= 1'b1;
                        state  <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_req && dmem_ready) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        retire   <= 1'b1;
                        state    <= S_WB;
                    end else begin
                        dmem_req <= 1'b1;
                    end
                end
                S_WB: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: begin
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    state    <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32/RV64 datapath with handshaked instruction and data memories;
// control signals come from an external decoder reading inst_field.
module multicycle_datapath
    import multicycle_datapath_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int              REG_NUM  = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [31:0]     inst_field,
    input  logic [1:0]      Jump,
    input  logic            Branch,
    input  logic            BranchN,
    input  logic [1:0]      MemtoReg,
    input  logic            MemRW,
    input  logic            MemRead,
    input  logic            ALUSrc_B,
    input  logic            RegWrite,
    input  logic [2:0]      ImmSel,
    input  logic [3:0]      ALU_operation,
    output logic [XLEN-1:0] PC_out,
    output logic [2:0]      state,
    output logic            retire
);

    localparam int RW = $clog2(REG_NUM);
    localparam int SW = $clog2(XLEN);

    state_t          state_s;
    logic [XLEN-1:0] pc_r, next_pc_r, a_r, b_r, alu_out_r, mdr_r;
    logic [31:0]     ir_r;
    logic [XLEN-1:0] regs_r [REG_NUM];
    logic [XLEN-1:0] imm_s, alu_b_s, alu_y_s, pc_plus4_s, next_pc_s, wb_data_s;
    logic            alu_zero_s;
    logic [RW-1:0]   rs1_s, rs2_s, rd_s;

    mc_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .mem_rw     (MemRW),
        .mem_read   (MemRead),
        .state      (state_s),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .retire     (retire)
    );

    assign rs1_s = ir_r[15 +: RW];
    assign rs2_s = ir_r[20 +: RW];
    assign rd_s  = ir_r[7 +: RW];

    // ALU on the latched operands, with the immediate widened to XLEN.
    always_comb begin
        imm_s   = XLEN'($signed(imm_gen(ir_r, ImmSel)));
        alu_b_s = ALUSrc_B ? imm_s : b_r;
        case (ALU_operation)
            ALU_ADD:  alu_y_s = a_r + alu_b_s;
            ALU_SUB:  alu_y_s = a_r - alu_b_s;
            ALU_AND:  alu_y_s = a_r & alu_b_s;
            ALU_OR:   alu_y_s = a_r | alu_b_s;
            ALU_XOR:  alu_y_s = a_r ^ alu_b_s;
            ALU_SLL:  alu_y_s = a_r << alu_b_s[SW-1:0];
            ALU_SRL:  alu_y_s = a_r >> alu_b_s[SW-1:0];
            ALU_SRA:  alu_y_s = $signed(a_r) >>> alu_b_s[SW-1:0];
            ALU_SLT:  alu_y_s = {{(XLEN-1){1'b0}}, ($signed(a_r) < $signed(alu_b_s))};
            ALU_SLTU: alu_y_s = {{(XLEN-1){1'b0}}, (a_r < alu_b_s)};
            default:  alu_y_s = {XLEN{1'b0}};
        endcase
        alu_zero_s = (alu_y_s == {XLEN{1'b0}});
    end

    // Next-PC selection evaluated in EXEC; jalr targets drop bit 0.
    always_comb begin
        pc_plus4_s = pc_r + XLEN'(32'd4);
        if (Jump == JUMP_JAL) begin
            next_pc_s = pc_r + imm_s;
        end else if (Jump == JUMP_JALR) begin
            next_pc_s = alu_y_s & ~XLEN'(32'd1);
        end else if ((Jump == JUMP_BRANCH) && ((Branch && alu_zero_s) || (BranchN && !alu_zero_s))) begin
            next_pc_s = pc_r + imm_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Writeback source; pc_r still holds the pre-update PC during WB.
    always_comb begin
        case (MemtoReg)
            WB_ALU:  wb_data_s = alu_out_r;
            WB_MEM:  wb_data_s = mdr_r;
            WB_PC4:  wb_data_s = pc_plus4_s;
            WB_IMM:  wb_data_s = imm_s;
            default: wb_data_s = alu_out_r;
        endcase
    end

    // Datapath registers and register file, updated according to the current state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r      <= RESET_PC;
            next_pc_r <= RESET_PC;
            ir_r      <= 32'h0000_0000;
            a_r       <= {XLEN{1'b0}};
            b_r       <= {XLEN{1'b0}};
            alu_out_r <= {XLEN{1'b0}};
            mdr_r     <= {XLEN{1'b0}};
            for (int i = 0; i < REG_NUM; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            case (state_s)
                S_FETCH: begin
                    if (imem_req && imem_ready) begin
                        ir_r <= imem_rdata;
                    end
                end
                S_DECODE: begin
                    a_r <= (rs1_s == {RW{1'b0}}) ? {XLEN{1'b0}} : regs_r[rs1_s];
                    b_r <= (rs2_s == {RW{1'b0}}) ? {XLEN{1'b0}} : regs_r[rs2_s];
                end
                S_EXEC: begin
                    alu_out_r <= alu_y_s;
                    next_pc_r <= next_pc_s;
                end
                S_MEM: begin
                    if (dmem_req && dmem_ready && MemRead) begin
                        mdr_r <= dmem_rdata;
                    end
                end
                S_WB: begin
                    if (RegWrite && (rd_s != {RW{1'b0}})) begin
                        regs_r[rd_s] <= wb_data_s;
                    end
                    pc_r <= next_pc_r;
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

    assign imem_addr  = pc_r;
    assign PC_out     = pc_r;
    assign dmem_addr  = alu_out_r;
    assign dmem_wdata = b_r;
    assign inst_field = ir_r;
    assign state      = state_s;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: behavioural memories with programmable wait
// states, a small decoder, and a scoreboard of per-instruction expectations.
module tb_multicycle_datapath;
    import multicycle_datapath_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            imem_req, imem_ready;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            dmem_req, dmem_we, dmem_ready;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0]     inst_field;
    logic [1:0]      Jump, MemtoReg;
    logic            Branch, BranchN, MemRW, MemRead, ALUSrc_B, RegWrite;
    logic [2:0]      ImmSel;
    logic [3:0]      ALU_operation;
    logic [XLEN-1:0] PC_out;
    logic [2:0]      state;
    logic            retire;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] next_pc;
        int          cycles;
        int          rd;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] imem_mem [32];
    logic [31:0] dmem_mem [16];
    int imem_lat = 0, imem_cnt = 0;
    int dmem_lat = 0, dmem_cnt = 0;
    logic stray_ready = 1'b0;

    logic        cap_seen, cap_we, cap_stable;
    logic [31:0] cap_addr, cap_wdata;
    int          req_cyc;

    always #5 clk = ~clk;

    multicycle_datapath #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .REG_NUM(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .inst_field(inst_field),
        .Jump(Jump), .Branch(Branch), .BranchN(BranchN), .MemtoReg(MemtoReg), .MemRW(MemRW),
        .MemRead(MemRead), .ALUSrc_B(ALUSrc_B), .RegWrite(RegWrite), .ImmSel(ImmSel),
        .ALU_operation(ALU_operation), .PC_out(PC_out), .state(state), .retire(retire)
    );

    // Memory models with wait-state counters.
    assign imem_ready = imem_req && (imem_cnt >= imem_lat);
    assign imem_rdata = imem_mem[imem_addr[6:2]];
    assign dmem_ready = (dmem_req && (dmem_cnt >= dmem_lat)) || stray_ready;
    assign dmem_rdata = dmem_mem[dmem_addr[5:2]];

    always @(posedge clk) begin
        imem_cnt <= (imem_req && !imem_ready) ? imem_cnt + 1 : 0;
        dmem_cnt <= (dmem_req && !dmem_ready) ? dmem_cnt + 1 : 0;
        if (dmem_req && dmem_ready && dmem_we) dmem_mem[dmem_addr[5:2]] <= dmem_wdata;
    end

    // External decoder for the handful of opcodes the program uses.
    always_comb begin
        Jump = JUMP_BRANCH; Branch = 1'b0; BranchN = 1'b0; MemtoReg = WB_ALU;
        MemRW = 1'b0; MemRead = 1'b0; ALUSrc_B = 1'b0; RegWrite = 1'b0;
        ImmSel = IMM_I; ALU_operation = ALU_ADD;
        case (inst_field[6:0])
            7'h13: begin ALUSrc_B = 1'b1; RegWrite = 1'b1; end
            7'h03: begin ALUSrc_B = 1'b1; RegWrite = 1'b1; MemRead = 1'b1; MemtoReg = WB_MEM; end
            7'h23: begin ALUSrc_B = 1'b1; MemRW = 1'b1; ImmSel = IMM_S; end
            7'h63: begin
                Branch = (inst_field[14:12] == 3'b000); BranchN = (inst_field[14:12] == 3'b001);
                ALU_operation = ALU_SUB; ImmSel = IMM_B;
            end
            7'h6F: begin Jump = JUMP_JAL; RegWrite = 1'b1; MemtoReg = WB_PC4; ImmSel = IMM_J; end
            7'h67: begin Jump = JUMP_JALR; RegWrite = 1'b1; MemtoReg = WB_PC4; ALUSrc_B = 1'b1; end
            default: ;
        endcase
    end

    task automatic expect_inst(input logic [31:0] addr, input logic [31:0] npc, input int cyc,
                               input int rd, input logic [31:0] val);
        exp_t e;
        e.addr = addr; e.next_pc = npc; e.cycles = cyc; e.rd = rd; e.val = val;
        sb_q.push_back(e);
    endtask

    // Runs one instruction from its fetch request to retire and scores it.
    task automatic run_one(input string name);
        exp_t e;
        int cyc;
        logic [31:0] a0;
        logic addr_ok;
        cyc = 0;
        while (imem_req !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        cyc = 1; req_cyc = 1; a0 = imem_addr; addr_ok = 1'b1;
        cap_seen = 1'b0; cap_stable = 1'b1; cap_we = 1'b0; cap_addr = '0; cap_wdata = '0;
        while (retire !== 1'b1 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (imem_req === 1'b1) begin
                req_cyc++;
                if (imem_addr !== a0) addr_ok = 1'b0;
            end
            if (dmem_req === 1'b1) begin
                if (cap_seen && (dmem_addr !== cap_addr || dmem_wdata !== cap_wdata || dmem_we !== cap_we))
                    cap_stable = 1'b0;
                cap_seen = 1'b1; cap_we = dmem_we; cap_addr = dmem_addr; cap_wdata = dmem_wdata;
            end
        end
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard: got empty queue required an entry", name);
            return;
        end
        e = sb_q.pop_front();
        checks++; if (cyc !== e.cycles) begin errors++; $display("FAIL %s cycles: got %0d required %0d", name, cyc, e.cycles); end
        checks++; if (a0 !== e.addr) begin errors++; $display("FAIL %s imem_addr: got %h required %h", name, a0, e.addr); end
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL %s addr_stable: got %b required 1", name, addr_ok); end
        @(negedge clk);
        checks++; if (PC_out !== e.next_pc) begin errors++; $display("FAIL %s next_pc: got %h required %h", name, PC_out, e.next_pc); end
        if (e.rd >= 0) begin
            checks++;
            if (dut.regs_r[e.rd] !== e.val) begin
                errors++; $display("FAIL %s x%0d: got %h required %h", name, e.rd, dut.regs_r[e.rd], e.val);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h required 0", PC_out); end
        checks++; if (inst_field !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h required 0", inst_field); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", state); end
        checks++; if ({imem_req, dmem_req, dmem_we, retire} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b required 0000", {imem_req, dmem_req, dmem_we, retire});
        end
        rst = 1'b1;
    endtask

    task automatic test_alu();
        expect_inst(32'h00, 32'h04, 4, 1, 32'd5);
        run_one("addi_x1");
    endtask

    task automatic test_store_load();
        dmem_lat = 2;
        expect_inst(32'h04, 32'h08, 7, -1, 32'd0);
        run_one("sw_x1");
        checks++; if (cap_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b required 1", cap_we); end
        checks++; if (cap_addr !== 32'd8) begin errors++; $display("FAIL sw_addr: got %h required 8", cap_addr); end
        checks++; if (cap_wdata !== 32'd5) begin errors++; $display("FAIL sw_wdata: got %h required 5", cap_wdata); end
        checks++; if (cap_stable !== 1'b1) begin errors++; $display("FAIL sw_stable: got %b required 1", cap_stable); end
        checks++; if (dmem_mem[2] !== 32'd5) begin errors++; $display("FAIL sw_mem: got %h required 5", dmem_mem[2]); end
        expect_inst(32'h08, 32'h0C, 7, 2, 32'd5);
        run_one("lw_x2");
        dmem_lat = 0;
    endtask

    task automatic test_imem_wait();
        imem_lat = 3;
        expect_inst(32'h0C, 32'h10, 7, 3, 32'd1);
        run_one("addi_wait");
        checks++; if (req_cyc !== 4) begin errors++; $display("FAIL imem_req_held: got %0d required 4", req_cyc); end
        imem_lat = 0;
    endtask

    task automatic test_branch();
        expect_inst(32'h10, 32'h20, 4, -1, 32'd0);
        run_one("beq_taken");
        imem_mem[4] = 32'h0000_1863;
        expect_inst(32'h20, 32'h10, 4, 0, 32'd0);
        run_one("jal_back");
        expect_inst(32'h10, 32'h14, 4, -1, 32'd0);
        run_one("bne_not_taken");
    endtask

    task automatic test_jump();
        expect_inst(32'h14, 32'h40, 4, 0, 32'd0);
        expect_inst(32'h40, 32'h4C, 4, 1, 32'h44);
        expect_inst(32'h4C, 32'h46, 4, 0, 32'd0);
        expect_inst(32'h46, 32'h4A, 4, 0, 32'd0);
        run_one("jal_fwd");
        run_one("jal_link");
        run_one("jalr_bit0");
        run_one("addi_x0");
        checks++; if (dut.regs_r[1] !== 32'h44) begin errors++; $display("FAIL x0_write_x1: got %h required 44", dut.regs_r[1]); end
    endtask

    task automatic test_reset_mid_mem();
        int n;
        dmem_lat = 1000;
        n = 0;
        while (dmem_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL mid_mem_req: got %b required 1", dmem_req); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_dmem_req: got %b required 0", dmem_req); end
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL rst_mid_pc: got %h required 0", PC_out); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_mid_state: got %0d required 0", state); end
        @(negedge clk);
        rst = 1'b1;
        imem_lat = 1000;
        stray_ready = 1'b1;
        repeat (2) @(negedge clk);
        stray_ready = 1'b0;
        @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL stray_state: got %0d required 0", state); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL stray_dmem_req: got %b required 0", dmem_req); end
        checks++; if (dut.mdr_r !== 32'h0) begin errors++; $display("FAIL stray_mdr: got %h required 0", dut.mdr_r); end
        checks++; if (dmem_mem[3] !== 32'h0) begin errors++; $display("FAIL stray_mem: got %h required 0", dmem_mem[3]); end
        checks++; if (dut.regs_r[1] !== 32'h0) begin errors++; $display("FAIL rst_regfile: got %h required 0", dut.regs_r[1]); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) imem_mem[i] = 32'h0000_0013;
        for (int i = 0; i < 16; i++) dmem_mem[i] = 32'h0;
        imem_mem[0]  = 32'h0050_0093;  // addi x1,x0,5
        imem_mem[1]  = 32'h0010_2423;  // sw x1,8(x0)
        imem_mem[2]  = 32'h0080_2103;  // lw x2,8(x0)
        imem_mem[3]  = 32'h0010_0193;  // addi x3,x0,1
        imem_mem[4]  = 32'h0000_0863;  // beq x0,x0,+16
        imem_mem[5]  = 32'h02C0_006F;  // jal x0,+44
        imem_mem[8]  = 32'hFF1F_F06F;  // jal x0,-16
        imem_mem[16] = 32'h00C0_00EF;  // jal x1,+12
        imem_mem[17] = 32'h0070_0013;  // addi x0,x0,7
        imem_mem[18] = 32'h0010_2623;  // sw x1,12(x0)
        imem_mem[19] = 32'h0030_8067;  // jalr x0,3(x1)
        @(negedge clk);
        test_reset();
        test_alu();
        test_store_load();
        test_imem_wait();
        test_branch();
        test_jump();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
